pipeline_hazard_controller: RTL and testbench

- Issue controller between the decode stage and the decode/execution pipeline registers of the 5-stage core.
- Tracks in-flight destination registers in a scoreboard shift register sized to the stages after decode. The pipeline has no forwarding, so the block stalls fetch/decode on a read-after-write hazard and injects a bubble.
- Provides a drain handshake so reset/debug logic can quiesce the pipeline before touching the register file.

---
 rtl/pipeline_hazard_controller.sv | 133 +++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Decode-stage issue controller for the no-forwarding 5-stage core: RAW stall/bubble via a
// destination scoreboard, plus a drain handshake. Define HAZARD_STATS_EN for stall/issue counters.
module pipeline_hazard_controller #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned PIPE_DEPTH     = 3
`ifdef HAZARD_STATS_EN
  , parameter int unsigned STAT_WIDTH   = 16
`endif
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      decode_valid,
  input  logic                      decode_writes,
  input  logic [REG_ADDR_WIDTH-1:0] decode_rs,
  input  logic                      decode_rs_used,
  input  logic [REG_ADDR_WIDTH-1:0] decode_rt,
  input  logic                      decode_rt_used,
  input  logic [REG_ADDR_WIDTH-1:0] decode_rd,
  input  logic                      drain_req,
  output logic                      stall,
  output logic                      issue,
  output logic                      bubble,
  output logic                      drain_ack,
  output logic                      busy
`ifdef HAZARD_STATS_EN
  , output logic [STAT_WIDTH-1:0]   stall_count
  , output logic [STAT_WIDTH-1:0]   issue_count
`endif
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t state_q, state_d;
  logic   drain_ack_q, drain_ack_d;
  logic   hazard_c;
  logic [PIPE_DEPTH-1:0]                     sb_valid_q, sb_valid_d;
  logic [PIPE_DEPTH-1:0][REG_ADDR_WIDTH-1:0] sb_addr_q, sb_addr_d;

  // Any in-flight write to a register decode reads; r0 is never a dependency.
  always_comb begin
    hazard_c = 1'b0;
    for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
      if (sb_valid_q[i] &&
          ((decode_rs_used && (decode_rs != '0) && (sb_addr_q[i] == decode_rs)) ||
           (decode_rt_used && (decode_rt != '0) && (sb_addr_q[i] == decode_rt))))
        hazard_c = 1'b1;
    end
    hazard_c = hazard_c && decode_valid;
  end

  assign busy      = |sb_valid_q;
  assign drain_ack = drain_ack_q;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    stall   = 1'b0;
    bubble  = 1'b1;
    if (!reset) begin
      case (state_q)
        RUN: begin
          issue  = decode_valid && !hazard_c;
          stall  = hazard_c;
          bubble = !issue;
          if (drain_req) state_d = DRAIN;
        end
        DRAIN: begin
          stall = decode_valid;
          if (!busy) state_d = HALTED;
        end
        HALTED: begin
          stall = decode_valid;
          if (!drain_req) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
    drain_ack_d = (state_d == HALTED);
  end

  // Downstream stages never stall, so the scoreboard shifts unconditionally.
  always_comb begin
    sb_valid_d[0] = issue && decode_writes && (decode_rd != '0);
    sb_addr_d[0]  = decode_rd;
    for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
      sb_valid_d[i] = sb_valid_q[i-1];
      sb_addr_d[i]  = sb_addr_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RUN;
      drain_ack_q <= 1'b0;
      sb_valid_q  <= '0;
      sb_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      drain_ack_q <= drain_ack_d;
      sb_valid_q  <= sb_valid_d;
      sb_addr_q   <= sb_addr_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic [STAT_WIDTH-1:0] issue_count_q, issue_count_d;

  // Saturating event counters.
  always_comb begin
    stall_count_d = stall_count_q;
    issue_count_d = issue_count_q;
    if ((state_q == RUN) && stall && !(&stall_count_q))
      stall_count_d = stall_count_q + STAT_WIDTH'(1);
    if (issue && !(&issue_count_q))
      issue_count_d = issue_count_q + STAT_WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count_q <= '0;
      issue_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      issue_count_q <= issue_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign issue_count = issue_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed scenarios then random traffic, checked against a
// model that tracks, per register, the first cycle at which its pending write has completed.
module tb_pipeline_hazard_controller;
  localparam int AW   = 5;
  localparam int PD   = 3;
  localparam int NREG = 1 << AW;
`ifdef HAZARD_STATS_EN
  localparam int SW   = 8;
  localparam int SMAX = (1 << SW) - 1;
`endif

  logic clock = 1'b0;
  logic rst, dv, dw, rsu, rtu, dreq;
  logic [AW-1:0] rs, rt, rd;
  logic stall, issue, bubble, drain_ack, busy;
`ifdef HAZARD_STATS_EN
  logic [SW-1:0] stall_count, issue_count;
`endif

  always #5 clock = ~clock;

  pipeline_hazard_controller #(
    .REG_ADDR_WIDTH(AW),
    .PIPE_DEPTH(PD)
`ifdef HAZARD_STATS_EN
    , .STAT_WIDTH(SW)
`endif
  ) dut (
    .clock(clock), .reset(rst),
    .decode_valid(dv), .decode_writes(dw),
    .decode_rs(rs), .decode_rs_used(rsu),
    .decode_rt(rt), .decode_rt_used(rtu),
    .decode_rd(rd), .drain_req(dreq),
    .stall(stall), .issue(issue), .bubble(bubble),
    .drain_ack(drain_ack), .busy(busy)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count), .issue_count(issue_count)
`endif
  );

  typedef enum {M_RUN, M_DRAIN, M_HALT} mode_t;

  int    tests = 0, failed = 0;
  int    pend[NREG];   // cycle from which the register is safe to read
  int    cyc = 0;
  mode_t mode = M_RUN;
  logic  last_iss = 1'b0, obs_iss, obs_ack;
  int    st_cnt = 0, is_cnt = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drv(logic v, logic w, int s, logic su, int t, logic tu, int d);
    dv = v; dw = w; rs = AW'(s); rsu = su; rt = AW'(t); rtu = tu; rd = AW'(d);
  endtask

  function automatic logic m_pending(logic [AW-1:0] r);
    return (r != '0) && (pend[r] > cyc);
  endfunction

  function automatic logic m_busy();
    for (int r = 0; r < NREG; r++)
      if (pend[r] > cyc) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: check outputs against the model, then advance the model at the edge.
  task automatic tick();
    logic haz, e_iss, e_stl, bsy;
    #1;
    bsy = m_busy();
    haz = dv && ((rsu && m_pending(rs)) || (rtu && m_pending(rt)));
    if (rst) begin
      e_iss = 1'b0; e_stl = 1'b0;
    end else if (mode == M_RUN) begin
      e_iss = dv && !haz; e_stl = haz;
    end else begin
      e_iss = 1'b0; e_stl = dv;
    end
    obs_iss = issue;
    obs_ack = drain_ack;
    chk("issue", 32'(issue), 32'(e_iss));
    chk("stall", 32'(stall), 32'(e_stl));
    chk("bubble", 32'(bubble), 32'(!e_iss));
    chk("busy", 32'(busy), 32'(bsy));
    chk("drain_ack", 32'(drain_ack), 32'(mode == M_HALT));
`ifdef HAZARD_STATS_EN
    chk("stall_count", 32'(stall_count), 32'(st_cnt));
    chk("issue_count", 32'(issue_count), 32'(is_cnt));
`endif
    @(posedge clock);
    if (rst) begin
      foreach (pend[r]) pend[r] = 0;
      mode = M_RUN; st_cnt = 0; is_cnt = 0;
    end else begin
      if (e_iss && dw && rd != '0) pend[rd] = cyc + PD + 1;
      if (mode == M_RUN && e_stl && st_cnt < (1 << 30)) st_cnt++;
      if (e_iss && is_cnt < (1 << 30)) is_cnt++;
`ifdef HAZARD_STATS_EN
      if (st_cnt > SMAX) st_cnt = SMAX;
      if (is_cnt > SMAX) is_cnt = SMAX;
`endif
      case (mode)
        M_RUN:   if (dreq) mode = M_DRAIN;
        M_DRAIN: if (!bsy) mode = M_HALT;
        default: if (!dreq) mode = M_RUN;
      endcase
    end
    last_iss = e_iss;
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle(int n);
    drv(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    foreach (pend[r]) pend[r] = 0;
    rst = 1'b1; dreq = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    @(negedge clock);
    tick();
    rst = 1'b0;
    idle(1);

    // Independent stream
    drv(1, 1, 1, 1, 2, 1, 3); tick();
    drv(1, 1, 4, 1, 5, 1, 6); tick();
    idle(4);

    // Back-to-back RAW costs exactly PD stalls
    drv(1, 1, 1, 1, 2, 1, 3); tick();
    drv(1, 1, 3, 1, 3, 1, 4);
    n = 0;
    do begin
      tick();
      if (!obs_iss) n++;
    end while (!obs_iss && n < 10);
    chk("raw_b2b_stalls", 32'(n), 32'(PD));
    idle(4);

    // RAW at distance 2
    drv(1, 1, 1, 1, 2, 1, 3); tick();
    drv(1, 1, 1, 1, 2, 1, 7); tick();
    drv(1, 1, 3, 1, 0, 0, 8); tick(); tick(); tick();
    idle(4);

    // r0 destination never blocks
    drv(1, 1, 1, 1, 2, 1, 0); tick();
    drv(1, 1, 0, 1, 0, 1, 5); tick();
    chk("r0_no_stall_issue", 32'(obs_iss), 32'd1);
    idle(4);

    // Drain with a hazard pending
    drv(1, 1, 4, 1, 5, 1, 1); tick();
    drv(1, 1, 4, 1, 5, 1, 2); tick();
    drv(1, 1, 4, 1, 5, 1, 3); tick();
    drv(1, 1, 1, 1, 2, 1, 8); dreq = 1'b1; tick();
    n = 0;
    while (!obs_ack && n < 20) begin tick(); n++; end
    chk("drain_ack_seen", 32'(obs_ack), 32'd1);
    dreq = 1'b0; tick();
    tick();
    chk("post_drain_issue", 32'(obs_iss), 32'd1);
    idle(4);

    // Reset mid-stall discards the scoreboard
    drv(1, 1, 1, 1, 2, 1, 9); tick();
    drv(1, 1, 9, 1, 0, 0, 10); tick();
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    chk("post_reset_issue", 32'(obs_iss), 32'd1);
    idle(4);

`ifdef HAZARD_STATS_EN
    // Self-dependent writer stalls 3 of every 4 cycles; run past saturation
    drv(1, 1, 1, 1, 0, 0, 1);
    for (int i = 0; i < ((SMAX + 6) * 4) / 3 + 8; i++) tick();
    chk("stall_count_sat", 32'(stall_count), 32'(SMAX));
    rst = 1'b1; tick();
    rst = 1'b0; idle(1);
`endif

    // Random traffic: decode holds an instruction until it issues
    for (int i = 0; i < 600; i++) begin
      if (last_iss || !dv)
        drv($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) dreq = !dreq;
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
